// File: rtl/dda_sample_streamer.sv
// dda_sample_streamer
//   Samples a signed 7.20 DDA state variable every 2^decim cycles and streams
//   it out as a byte frame over a valid/ready handshake.
//   Ports:
//     clk, rst_n        clock, async active-low reset
//     state_in[26:0]    signed 7.20 sample source, captured on WAIT->SEND
//                       or on a back-to-back recapture in SEND
//     run               1 = keep streaming, 0 = finish frame then idle
//     decim[3:0]        sample period 2^decim cycles
//     compact           0 = 4-byte big-endian frame, 1 = 1-byte saturated Q3.4
//     ready_in          consumer ready
//     clr_ovr           clears overrun (a same-edge set wins)
//     data_out[7:0]     current byte, 0 when not valid
//     valid_out/sof_out byte valid / first byte of frame
//     busy              high in WAIT and SEND
//     overrun           sticky: a sample tick was dropped
module dda_sample_streamer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [26:0] state_in,
  input  logic        run,
  input  logic [3:0]  decim,
  input  logic        compact,
  input  logic        ready_in,
  input  logic        clr_ovr,
  output logic [7:0]  data_out,
  output logic        valid_out,
  output logic        sof_out,
  output logic        busy,
  output logic        overrun
);
  typedef enum logic [1:0] {IDLE, WAIT, SEND} state_t;

  state_t      state, state_nxt;
  logic [14:0] cnt, mask;
  logic [26:0] sample;
  logic        cmp_q;
  logic [1:0]  idx;
  logic        tick, in_send, last, xfer, last_xfer, capture, ovr_set;
  logic [31:0] full_word;
  logic [7:0]  full_byte, cmp_byte;

  // decim=15 gives 1<<15 which still fits 16 bits; the mask fits 15.
  assign mask      = 15'((16'd1 << decim) - 16'd1);
  assign tick      = (cnt & mask) == mask;
  assign in_send   = (state == SEND);
  assign last      = cmp_q | (idx == 2'd3);
  assign xfer      = in_send & ready_in;
  assign last_xfer = xfer & last;
  // Back-to-back recapture on the last transfer avoids a bubble cycle.
  assign capture   = run & tick & ((state == WAIT) | last_xfer);
  assign ovr_set   = in_send & tick & ~last_xfer;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; run=0 only ends a frame after its last byte.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (run) state_nxt = WAIT;
      WAIT: begin
        if (!run)      state_nxt = IDLE;
        else if (tick) state_nxt = SEND;
      end
      SEND: begin
        if (last_xfer) begin
          if (run && tick) state_nxt = SEND;
          else if (run)    state_nxt = WAIT;
          else             state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: decimation counter, sample capture, byte index, overrun
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      sample  <= '0;
      cmp_q   <= 1'b0;
      idx     <= '0;
      overrun <= 1'b0;
    end else begin
      // Counter reads 0 throughout IDLE, including the first IDLE cycle.
      if (state == IDLE || state_nxt == IDLE) cnt <= '0;
      else                                    cnt <= cnt + 15'd1;

      if (capture) begin
        sample <= state_in;
        cmp_q  <= compact;
        idx    <= '0;
      end else if (xfer && !last) begin
        idx <= idx + 2'd1;
      end

      if (ovr_set)      overrun <= 1'b1;
      else if (clr_ovr) overrun <= 1'b0;
    end
  end

  // Output logic
  always_comb begin
    full_word = {{5{sample[26]}}, sample};
    case (idx)
      2'd0:    full_byte = full_word[31:24];
      2'd1:    full_byte = full_word[23:16];
      2'd2:    full_byte = full_word[15:8];
      default: full_byte = full_word[7:0];
    endcase
    // Q3.4 fits only when the top four bits agree; otherwise saturate.
    if (sample[26:23] == 4'h0 || sample[26:23] == 4'hF) cmp_byte = sample[23:16];
    else if (sample[26])                                cmp_byte = 8'h80;
    else                                                cmp_byte = 8'h7F;

    valid_out = in_send;
    sof_out   = in_send & (idx == 2'd0);
    busy      = (state != IDLE);
    data_out  = in_send ? (cmp_q ? cmp_byte : full_byte) : 8'h00;
  end
endmodule

// File: tb/tb_dda_sample_streamer.sv
module tb_dda_sample_streamer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [26:0] state_in;
  logic        run, compact, ready_in, clr_ovr;
  logic [3:0]  decim;
  logic [7:0]  data_out;
  logic        valid_out, sof_out, busy, overrun;

  int checks = 0;
  int errors = 0;

  dda_sample_streamer dut (
    .clk(clk), .rst_n(rst_n), .state_in(state_in), .run(run), .decim(decim),
    .compact(compact), .ready_in(ready_in), .clr_ovr(clr_ovr),
    .data_out(data_out), .valid_out(valid_out), .sof_out(sof_out),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: a running flag, a cycle count since leaving idle,
  // and a queue of bytes still owed for the current frame.
  bit         m_act = 0;
  int         m_n = 0;
  bit         m_first = 0;
  bit         m_ovr = 0;
  logic [7:0] m_q[$];

  function automatic void push_frame(input logic [26:0] s, input bit cmp);
    int          v, qv;
    logic [31:0] u;
    v = int'($signed(s));
    u = v;
    m_q.delete();
    if (cmp) begin
      qv = v >>> 16;
      if (qv > 127)       m_q.push_back(8'h7F);
      else if (qv < -128) m_q.push_back(8'h80);
      else                m_q.push_back(8'(qv));
    end else begin
      m_q.push_back(u[31:24]); m_q.push_back(u[23:16]);
      m_q.push_back(u[15:8]);  m_q.push_back(u[7:0]);
    end
    m_first = 1;
  endfunction

  function automatic void model_edge();
    int p;
    bit t, set, last_x;
    set = 0;
    if (!rst_n) begin
      m_act = 0; m_n = 0; m_q.delete(); m_ovr = 0; m_first = 0;
      return;
    end
    if (!m_act) begin
      if (run) begin m_act = 1; m_n = 0; end
    end else begin
      p = 1 << decim;
      t = (m_n % p) == p - 1;
      if (m_q.size() > 0) begin
        last_x = ready_in && m_q.size() == 1;
        if (t && !last_x) set = 1;
        if (ready_in) begin
          void'(m_q.pop_front());
          m_first = 0;
          if (m_q.size() == 0) begin
            if (run && t)  push_frame(state_in, compact);
            else if (!run) m_act = 0;
          end
        end
      end else begin
        if (!run)   m_act = 0;
        else if (t) push_frame(state_in, compact);
      end
      m_n = m_act ? (m_n + 1) % 32768 : 0;
    end
    if (set)          m_ovr = 1;
    else if (clr_ovr) m_ovr = 0;
  endfunction

  task automatic cyc();
    bit v;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    v = m_q.size() > 0;
    chk("valid",   valid_out, v);
    chk("sof",     sof_out,   v && m_first);
    chk("data",    data_out,  v ? m_q[0] : 8'h00);
    chk("busy",    busy,      m_act);
    chk("overrun", overrun,   m_ovr);
  endtask

  task automatic wait_sof();
    int n = 0;
    do begin cyc(); n++; end while (!sof_out && n < 64);
    if (!sof_out) chk("sof_timeout", 0, 1);
  endtask

  logic [7:0] cvals[3] = '{8'h50, 8'h7F, 8'h80};
  logic [26:0] cins[3] = '{27'h0500000, 27'h0A00000, 27'h7600000};

  initial begin
    rst_n = 0; run = 0; decim = 0; compact = 0; ready_in = 1; clr_ovr = 0;
    state_in = '0;
    #1;
    chk("rst_valid", valid_out, 0);
    chk("rst_busy",  busy, 0);
    chk("rst_ovr",   overrun, 0);
    chk("rst_data",  data_out, 0);
    repeat (2) cyc();
    rst_n = 1;

    // Full frame, positive value
    run = 1; decim = 2; state_in = 27'h0500000;
    wait_sof(); chk("pos_b0", data_out, 8'h00);
    cyc();      chk("pos_b1", data_out, 8'h50);
    repeat (14) cyc();
    chk("pos_ovr", overrun, 0);

    // Full frame, negative value
    state_in = 27'h7F00000;
    repeat (8) cyc();
    wait_sof(); chk("neg_b0", data_out, 8'hFF);
    cyc();      chk("neg_b1", data_out, 8'hF0);
    cyc();      chk("neg_b2", data_out, 8'h00);

    // Compact frames and saturation
    compact = 1;
    for (int i = 0; i < 3; i++) begin
      state_in = cins[i];
      repeat (8) cyc();
      wait_sof(); chk("cmp_byte", data_out, cvals[i]);
    end

    // Continuous streaming
    decim = 0;
    repeat (6) cyc();
    for (int i = 0; i < 20; i++) begin
      state_in = 27'($urandom);
      cyc(); chk("stream_valid", valid_out, 1);
    end
    chk("stream_ovr", overrun, 0);

    // Backpressure then overrun clear
    compact = 0; state_in = 27'h0500000;
    repeat (6) cyc();
    ready_in = 0;
    repeat (10) cyc();
    chk("bp_ovr", overrun, 1);
    clr_ovr = 1; ready_in = 1;
    cyc();
    clr_ovr = 0;
    repeat (4) cyc();

    // Reset during byte 2
    decim = 3;
    repeat (10) cyc();
    wait_sof(); cyc(); cyc();
    #2 rst_n = 0;
    #1;
    chk("async_valid", valid_out, 0);
    chk("async_busy",  busy, 0);
    repeat (2) cyc();
    rst_n = 1;

    // Run dropped during byte 1: frame must complete
    wait_sof(); cyc();
    run = 0;
    repeat (6) cyc();
    chk("stop_busy", busy, 0);

    // Randomized traffic
    run = 1;
    for (int i = 0; i < 3000; i++) begin
      state_in = 27'($urandom);
      if ($urandom_range(0, 19) == 0) run = ~run;
      if ($urandom_range(0, 15) == 0) decim = 4'($urandom_range(0, 4));
      compact  = 1'($urandom);
      ready_in = $urandom_range(0, 9) < 7;
      clr_ovr  = $urandom_range(0, 19) == 0;
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
